// File: rtl/multi_phase_sequencer.sv
// multi_phase_sequencer
// N-phase handshake sequencer for leg/gait control. Each phase waits for its
// own advance request, optionally after a minimum dwell time, and an optional
// watchdog returns a stalled phase (other than phase 0) to phase 0 and raises
// a sticky error. Runs cyclically or one-shot, and counts completed passes.
module multi_phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int MIN_DWELL  = 0,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = 16,
  localparam int PHASE_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  mode_cyclic,
  input  logic [NUM_PHASES-1:0] advance,
  output logic [NUM_PHASES-1:0] take,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      cycle_cnt
);

  // The dwell counter only needs to reach the larger of the two thresholds.
  localparam int DWELL_MAX = (MIN_DWELL > TIMEOUT) ? MIN_DWELL : TIMEOUT;
  localparam int DWELL_W   = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;

  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE_HOT0   = NUM_PHASES'(1);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [PHASE_W-1:0]      phase_n;
  logic [NUM_PHASES-1:0]   onehot_n;
  logic [DWELL_W-1:0]      dwell;
  logic [DWELL_W-1:0]      dwell_n;
  logic                    err_n;
  logic [CNT_W-1:0]        cnt_n;

  logic                    illegal;
  logic                    dwell_ok;
  logic                    wd_hit;
  logic                    accept;
  logic                    at_last;
  logic [NUM_PHASES-1:0]   phase_dec;

  // An index past the last phase can only exist for non-power-of-two counts;
  // the extra leading zero keeps the compare correct for power-of-two counts.
  assign illegal   = ({1'b0, phase_idx} >= (PHASE_W + 1)'(NUM_PHASES));

  // Decode of the current index; shifting past the top yields all zeros,
  // so an illegal index can never select an advance bit.
  assign phase_dec = ONE_HOT0 << phase_idx;
  assign at_last   = (phase_idx == LAST_PHASE);

  generate
    if (MIN_DWELL == 0) begin : g_no_dwell
      assign dwell_ok = 1'b1;
    end else begin : g_dwell
      assign dwell_ok = (dwell >= DWELL_W'(MIN_DWELL));
    end

    if (TIMEOUT == 0) begin : g_no_wd
      assign wd_hit = 1'b0;
    end else begin : g_wd
      assign wd_hit = (phase_idx != '0) && (dwell == DWELL_W'(TIMEOUT - 1));
    end
  endgenerate

  // A transition is accepted only for the current phase, once dwell is met,
  // while running, enabled and not being cleared or reset.
  assign accept = !rst && en && !clear && (state == ST_RUN) && !illegal &&
                  dwell_ok && (|(advance & phase_dec));
  assign take   = accept ? phase_dec : '0;
  assign done   = (state == ST_DONE);

  // Next-state selection in priority order: clear, illegal recovery,
  // accepted transition, watchdog expiry, then dwell counting.
  always_comb begin
    state_n  = state;
    phase_n  = phase_idx;
    dwell_n  = dwell;
    err_n    = timeout_err;
    cnt_n    = cycle_cnt;
    onehot_n = phase_onehot;

    if (clear) begin
      state_n = ST_RUN;
      phase_n = '0;
      dwell_n = '0;
      err_n   = 1'b0;
    end else if (illegal) begin
      state_n = ST_RUN;
      phase_n = '0;
      dwell_n = '0;
    end else if (en && (state == ST_RUN)) begin
      if (accept) begin
        dwell_n = '0;
        if (at_last) begin
          cnt_n = cycle_cnt + CNT_W'(1);
          if (mode_cyclic) begin
            phase_n = '0;
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          phase_n = phase_idx + PHASE_W'(1);
        end
      end else if (wd_hit) begin
        phase_n = '0;
        dwell_n = '0;
        err_n   = 1'b1;
      end else if (dwell != DWELL_W'(DWELL_MAX)) begin
        dwell_n = dwell + DWELL_W'(1);
      end
    end

    onehot_n = (state_n == ST_DONE) ? '0 : (ONE_HOT0 << phase_n);
  end

  // State register with asynchronous reset back to phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      phase_idx    <= '0;
      phase_onehot <= ONE_HOT0;
      dwell        <= '0;
      timeout_err  <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      state        <= state_n;
      phase_idx    <= phase_n;
      phase_onehot <= onehot_n;
      dwell        <= dwell_n;
      timeout_err  <= err_n;
      cycle_cnt    <= cnt_n;
    end
  end

endmodule

// File: doc/multi_phase_sequencer.md
Name: multi_phase_sequencer

Overview:
- Parametrised N-phase handshake sequencer for leg/gait control.
- Steps through phases 0..NUM_PHASES-1. Each phase advances when its own advance input is asserted.
- Adds the following over a fixed 3-phase machine: configurable phase count, minimum dwell per phase, per-phase watchdog timeout, cyclic or one-shot mode, enable/freeze, synchronous clear, and a completed-cycle counter.

Parameters:
- NUM_PHASES, 3, number of phases; legal range 2..16.
- MIN_DWELL, 0, cycles a phase must be occupied before its advance is accepted; 0 = accept on the entry cycle.
- TIMEOUT, 0, watchdog limit in cycles for phases 1..NUM_PHASES-1; 0 = watchdog disabled; when nonzero, must be > MIN_DWELL.
- CNT_W, 16, width of cycle_cnt.
- PHASE_W, derived localparam, clog2(NUM_PHASES), minimum 1.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- en, input, 1, advance/count enable; low freezes all state.
- clear, input, 1, synchronous return to phase 0; also clears done, timeout_err and the dwell counter.
- mode_cyclic, input, 1, 1 = last phase wraps to phase 0; 0 = one-shot, last phase goes to DONE.
- advance, input, NUM_PHASES, bit i is the advance request for phase i.
- take, output, NUM_PHASES, combinational; bit i = the phase i transition is accepted this cycle.
- phase_onehot, output, NUM_PHASES, registered one-hot of the current phase; all zero in DONE.
- phase_idx, output, PHASE_W, registered current phase index.
- done, output, 1, registered; high while in the one-shot DONE state.
- timeout_err, output, 1, registered sticky watchdog flag.
- cycle_cnt, output, CNT_W, count of completed 0..N-1 passes.

Behaviour:
- Reset (async, rst high):
  - phase_idx=0, phase_onehot=1 (bit 0), done=0, timeout_err=0, cycle_cnt=0, dwell counter=0.
  - take is 0 while rst is high.
- State: phase_idx register plus DONE flag. Also an internal dwell counter, cleared on phase entry, incrementing each enabled cycle, saturating at max(MIN_DWELL, TIMEOUT).
- Acceptance condition: dwell_ok = (dwell >= MIN_DWELL).
- take[i] = en & !clear & !done & (phase_idx==i) & advance[i] & dwell_ok. At most one bit is set.
- Transition on take[i]:
  - i < N-1: phase_idx <= i+1.
  - i == N-1 with mode_cyclic=1: phase_idx <= 0 and cycle_cnt increments.
  - i == N-1 with mode_cyclic=0: done <= 1, phase_onehot <= 0, phase_idx holds N-1, and cycle_cnt increments.
- Latency: the registered outputs reflect the new phase one cycle after take.
- advance while dwell_ok is low is ignored; the request is not latched and must still be held when dwell_ok rises.
- Watchdog (TIMEOUT > 0, phase_idx != 0, en=1):
  - If dwell == TIMEOUT-1 and there is no take, next state is phase 0, timeout_err <= 1, and cycle_cnt is unchanged.
  - Phase 0 is exempt (idle wait).
- Priority: rst > clear > take > watchdog > hold.
- Advance and timeout on the same cycle: advance wins, no error.
- en=0:
  - Phase, dwell, done and cycle_cnt are frozen; take=0.
  - clear still acts.
- DONE: holds until clear. Toggling mode_cyclic while in DONE has no effect.
- mode_cyclic is sampled only at the last-phase take.
- Illegal phase_idx (>= NUM_PHASES, non-power-of-2 N): forced to phase 0 on the next clock regardless of en; take=0 while illegal.
- cycle_cnt wraps modulo 2^CNT_W and never saturates.
- clear asserted mid-phase: next cycle phase 0 with dwell=0, and cycle_cnt is preserved.

Test Plan:
- N=3, MIN_DWELL=0, TIMEOUT=0, cyclic; pulse advance[0], [1], [2] on consecutive cycles -> take 001, 010, 100 on those same cycles; phase_idx 0→1→2→0; cycle_cnt=1.
- N=5, MIN_DWELL=3; hold advance[0] high from the phase 0 entry cycle -> take[0] asserted exactly on the 4th cycle (dwell=3); phase_idx=1 on the next edge; dwell restarts at 0.
- N=4, TIMEOUT=10; reach phase 2, then no advance -> after 10 cycles phase_idx=0 and timeout_err=1; timeout_err stays 1 through later cycles until clear.
- N=4, one-shot; walk all 4 phases -> done=1, phase_onehot=0000, cycle_cnt=1; further advances give take=0; clear -> phase_idx=0, done=0, cycle_cnt still 1.
- en=0 held 20 cycles in phase 1 with TIMEOUT=5 and advance[1]=1 -> no take, no timeout, phase unchanged; en=1 -> take[1] the same cycle.
- rst pulse asserted asynchronously mid-phase 2, CNT_W=4 with cycle_cnt=15 -> outputs reset immediately without a clock edge; separately, 16 cyclic passes from 0 -> cycle_cnt wraps to 0.
